// File: rtl/param_cam_if.sv
// rtl/param_cam_if.sv - lookup/update stream bundle for param_cam
interface param_cam_if #(
  parameter int KEY_W = 64,
  parameter int VAL_W = 16,
  parameter int DEPTH = 32,
  parameter int SRC_W = 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  localparam int LKQ_W = SRC_W + KEY_W;
  localparam int LKR_W = SRC_W + 1 + VAL_W + KEY_W;
  localparam int UPQ_W = SRC_W + 2 + VAL_W + KEY_W;
  localparam int UPR_W = SRC_W + 3 + VAL_W + KEY_W;

  logic [LKQ_W-1:0] s_lookup_TDATA;
  logic             s_lookup_TVALID;
  logic             s_lookup_TREADY;
  logic [LKR_W-1:0] m_lookup_TDATA;
  logic             m_lookup_TVALID;
  logic             m_lookup_TREADY;
  logic [UPQ_W-1:0] s_update_TDATA;
  logic             s_update_TVALID;
  logic             s_update_TREADY;
  logic [UPR_W-1:0] m_update_TDATA;
  logic             m_update_TVALID;
  logic             m_update_TREADY;
  logic [CNT_W-1:0] free_slots;

  modport master (
    output s_lookup_TDATA, s_lookup_TVALID, m_lookup_TREADY,
    output s_update_TDATA, s_update_TVALID, m_update_TREADY,
    input  s_lookup_TREADY, m_lookup_TDATA, m_lookup_TVALID,
    input  s_update_TREADY, m_update_TDATA, m_update_TVALID,
    input  free_slots
  );

  modport slave (
    input  s_lookup_TDATA, s_lookup_TVALID, m_lookup_TREADY,
    input  s_update_TDATA, s_update_TVALID, m_update_TREADY,
    output s_lookup_TREADY, m_lookup_TDATA, m_lookup_TVALID,
    output s_update_TREADY, m_update_TDATA, m_update_TVALID,
    output free_slots
  );
endinterface

// File: rtl/param_cam.sv
// rtl/param_cam.sv - fully-associative key/value CAM with lookup and update streams
module param_cam #(
  parameter int KEY_W = 64,
  parameter int VAL_W = 16,
  parameter int DEPTH = 32,
  parameter int SRC_W = 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  param_cam_if.slave  cam
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LKR_W = SRC_W + 1 + VAL_W + KEY_W;
  localparam int UPR_W = SRC_W + 3 + VAL_W + KEY_W;

  localparam logic [1:0] OP_INSERT = 2'b00;
  localparam logic [1:0] OP_DELETE = 2'b01;
  localparam logic [1:0] OP_MODIFY = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [KEY_W-1:0]   key_q [DEPTH];
  logic [KEY_W-1:0]   key_d [DEPTH];
  logic [VAL_W-1:0]   val_q [DEPTH];
  logic [VAL_W-1:0]   val_d [DEPTH];
  logic [CNT_W-1:0]   free_q, free_d;

  logic [SRC_W-1:0]   req_src_q, req_src_d;
  logic [1:0]         req_op_q, req_op_d;
  logic [VAL_W-1:0]   req_val_q, req_val_d;
  logic [KEY_W-1:0]   req_key_q, req_key_d;
  logic [UPR_W-1:0]   up_data_q, up_data_d;

  logic               lk_valid_q, lk_valid_d;
  logic [LKR_W-1:0]   lk_data_q, lk_data_d;

  logic [SRC_W-1:0]   lk_src;
  logic [KEY_W-1:0]   lk_key;
  logic               lk_hit;
  logic [VAL_W-1:0]   lk_val;
  logic               lk_ready;
  logic               up_ready;

  logic               match_any, free_any, success;
  logic [IDX_W-1:0]   match_idx, free_idx;
  logic [VAL_W-1:0]   rep_val;

  assign lk_src   = cam.s_lookup_TDATA[KEY_W +: SRC_W];
  assign lk_key   = cam.s_lookup_TDATA[KEY_W-1:0];
  assign lk_ready = !ap_rst && (!lk_valid_q || cam.m_lookup_TREADY);
  assign up_ready = !ap_rst && (state_q == S_IDLE);

  assign cam.s_lookup_TREADY = lk_ready;
  assign cam.m_lookup_TVALID = lk_valid_q;
  assign cam.m_lookup_TDATA  = lk_data_q;
  assign cam.s_update_TREADY = up_ready;
  assign cam.m_update_TVALID = (state_q == S_RESP);
  assign cam.m_update_TDATA  = up_data_q;
  assign cam.free_slots      = free_q;

  // Keys are unique, so OR-ing the hit values selects the single match.
  always_comb begin
    lk_hit = 1'b0;
    lk_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && key_q[i] == lk_key) begin
        lk_hit = 1'b1;
        lk_val = lk_val | val_q[i];
      end
    end
  end

  always_comb begin
    lk_valid_d = lk_valid_q;
    lk_data_d  = lk_data_q;
    if (cam.s_lookup_TVALID && lk_ready) begin
      lk_valid_d = 1'b1;
      lk_data_d  = {lk_src, lk_hit, lk_val, lk_key};
    end else if (cam.m_lookup_TREADY) begin
      lk_valid_d = 1'b0;
    end
  end

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && key_q[i] == req_key_q) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    key_d     = key_q;
    val_d     = val_q;
    free_d    = free_q;
    req_src_d = req_src_q;
    req_op_d  = req_op_q;
    req_val_d = req_val_q;
    req_key_d = req_key_q;
    up_data_d = up_data_q;
    success   = 1'b0;
    rep_val   = req_val_q;
    case (state_q)
      S_IDLE: begin
        if (cam.s_update_TVALID && up_ready) begin
          {req_src_d, req_op_d, req_val_d, req_key_d} = cam.s_update_TDATA;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (req_op_q)
          OP_INSERT: begin
            if (match_any) begin
              rep_val = val_q[match_idx];
            end else if (free_any) begin
              valid_d[free_idx] = 1'b1;
              key_d[free_idx]   = req_key_q;
              val_d[free_idx]   = req_val_q;
              free_d            = free_q - CNT_W'(1);
              success           = 1'b1;
            end
          end
          OP_DELETE: begin
            if (match_any) begin
              valid_d[match_idx] = 1'b0;
              rep_val            = val_q[match_idx];
              free_d             = free_q + CNT_W'(1);
              success            = 1'b1;
            end else begin
              rep_val = '0;
            end
          end
          OP_MODIFY: begin
            if (match_any) begin
              val_d[match_idx] = req_val_q;
              success          = 1'b1;
            end
          end
          default: begin
            valid_d = '0;
            free_d  = CNT_W'(DEPTH);
            success = 1'b1;
          end
        endcase
        up_data_d = {req_src_q, success, req_op_q, rep_val, req_key_q};
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (cam.m_update_TREADY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      free_q     <= CNT_W'(DEPTH);
      req_src_q  <= '0;
      req_op_q   <= '0;
      req_val_q  <= '0;
      req_key_q  <= '0;
      up_data_q  <= '0;
      lk_valid_q <= 1'b0;
      lk_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      free_q     <= free_d;
      req_src_q  <= req_src_d;
      req_op_q   <= req_op_d;
      req_val_q  <= req_val_d;
      req_key_q  <= req_key_d;
      up_data_q  <= up_data_d;
      lk_valid_q <= lk_valid_d;
      lk_data_q  <= lk_data_d;
    end
  end

  // Key/value storage is qualified by valid_q and needs no reset.
  always_ff @(posedge ap_clk) begin
    key_q <= key_d;
    val_q <= val_d;
  end
endmodule

// File: doc/param_cam.md
Name: param_cam

Overview:
- Parametrised, fully-associative key/value CAM for the session-lookup path.
- Implemented in native RTL; successor to the fixed-width HLS cuckoo CAM.
- Provides the same two-channel split: a lookup stream and an update stream.
- Adds configurable key/value/depth, source tagging, delete/modify/clear operations, explicit failure reporting and a live free-slot count.

Parameters:
- KEY_W, 64, key width in bits.
- VAL_W, 16, value width in bits.
- DEPTH, 32, number of entries (2..256).
- SRC_W, 1, requester tag width; the tag is echoed in replies.
- CNT_W, $clog2(DEPTH+1), width of free_slots.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  asynchronous active-high reset.
- s_lookup_TDATA  in  SRC_W+KEY_W  {src, key}; key is in the LSBs.
- s_lookup_TVALID  in  1  lookup request valid.
- s_lookup_TREADY  out  1  lookup request ready.
- m_lookup_TDATA  out  SRC_W+1+VAL_W+KEY_W  {src, hit, value, key}.
- m_lookup_TVALID  out  1  lookup reply valid.
- m_lookup_TREADY  in  1  lookup reply ready.
- s_update_TDATA  in  SRC_W+2+VAL_W+KEY_W  {src, op[1:0], value, key}.
- s_update_TVALID  in  1  update request valid.
- s_update_TREADY  out  1  update request ready.
- m_update_TDATA  out  SRC_W+1+2+VAL_W+KEY_W  {src, success, op, value, key}.
- m_update_TVALID  out  1  update reply valid.
- m_update_TREADY  in  1  update reply ready.
- free_slots  out  CNT_W  number of invalid entries.

Behaviour:
- Reset (async, active-high):
  - All entry valid bits cleared.
  - free_slots = DEPTH.
  - Both m_*_TVALID = 0.
  - Both s_*_TREADY = 0 while ap_rst is high.
  - Reply TDATA = 0.
  - Any in-flight request is discarded with no reply.
- Storage: DEPTH entries of {valid, key, value}, held in registers. Matching is a parallel equality compare on valid entries. Keys are unique by construction.
- Lookup path (single register stage):
  - s_lookup_TREADY = !m_lookup_TVALID || m_lookup_TREADY.
  - On accept, the compare runs against the table contents in that cycle. The reply is registered and valid on the next cycle, giving 1-cycle latency and full throughput under continuous ready.
  - Hit: value = stored value, hit = 1.
  - Miss: value = 0, hit = 0.
  - key and src are always echoed.
  - The reply holds stable while TVALID=1 and TREADY=0.
- Update path FSM, states IDLE, EXEC, RESP:
  - IDLE: s_update_TREADY = 1. On accept, latch the request and go to EXEC.
  - EXEC: compute match index and lowest-index free slot, apply the table write at the clock edge, load the reply register, go to RESP. s_update_TREADY = 0.
  - RESP: m_update_TVALID = 1. On m_update_TREADY, go to IDLE. An update is accepted at most once every 3 cycles.
- Update op encoding:
  - 00 INSERT:
    - Key present: success = 0; reply value = existing value; table unchanged.
    - Else, free slot exists: write to the lowest free index; success = 1.
    - Else: success = 0 (full).
  - 01 DELETE: if present, invalidate the entry; success = 1; reply value = deleted value. Else success = 0, value = 0.
  - 10 MODIFY: if present, overwrite the value; success = 1; reply value = new value. Else success = 0.
  - 11 CLEAR: invalidate all entries; success = 1; key and value echoed.
- free_slots: registered and updated in the same edge as the table write.
  - INSERT success decrements it by 1.
  - DELETE success increments it by 1.
  - CLEAR sets it to DEPTH.
  - Never wraps.
- Simultaneous lookup accept and update write in the same cycle: the lookup sees the pre-write table. Lookups accepted from the next cycle see the new contents.
- Lookup and update backpressure are independent; one stalled channel never blocks the other.

Test Plan:
- Reset, then lookup key 0x1234 -> 1 cycle later: m_lookup hit=0, value=0, key=0x1234; free_slots=32.
- INSERT key 0xA, value 0x55 -> success=1, free_slots=31. Then lookup 0xA with src=1 -> hit=1, value=0x55, src=1. Repeat the INSERT of 0xA with value 0x66 -> success=0, reply value=0x55.
- Fill all 32 slots with keys 1..32 -> each succeeds; free_slots=0. A 33rd INSERT -> success=0. DELETE key 5 -> success=1, free_slots=1. The next INSERT lands in index 4 and is retrievable by lookup.
- MODIFY and DELETE on a missing key -> success=0 and the table is unchanged. CLEAR -> free_slots=32 and all prior keys miss.
- Hold m_lookup_TREADY=0 for 5 cycles with 3 lookups queued -> exactly 1 reply is held stable and s_lookup_TREADY=0. Meanwhile an update completes normally. After release, the remaining lookups return back-to-back.
- Assert ap_rst during EXEC of an INSERT -> no update reply; free_slots=32; the key misses afterwards.
